pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
- Parametrised, pipelined add/subtract unit for the ALU datapath; successor to the 8-bit combinational adder.
- Splits a WIDTH-bit operation into STAGES carry-chained chunks, one chunk per stage.
- Valid/ready handshake on both input and output; supports subtract mode, carry-in and status flags.
- Intended for multi-cycle and pipelined core variants where a full-width combinational carry chain limits fmax.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; chunk width CW = WIDTH/STAGES; STAGES >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  unit accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1 = subtract (A - B), 0 = add
- cin  input  1  carry-in (add) / borrow-in (sub)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  signed overflow
- zero  output  1  sum == 0
- neg  output  1  sum[WIDTH-1]

Behaviour:
- Reset: rst_n low asynchronously clears all stage valid bits, out_valid, sum, cout, ovf, zero and neg to 0. In-flight operations are discarded. in_ready is 1 from the first cycle after reset release.
- Operand prep: b_eff = sub ? ~b : b; c0 = cin ^ sub.
  - sub=0: A + B + cin.
  - sub=1, cin=0: A - B.
  - sub=1, cin=1: A - B - 1.
- Pipeline structure:
  - Stage k (0..STAGES-1) adds chunk k of a and b_eff plus the carry registered from stage k-1 (c0 for stage 0).
  - Not-yet-added chunks travel in skew registers.
  - Completed chunks travel in deskew registers.
- Latency: an operation accepted at edge N presents out_valid=1 with its full result after edge N+STAGES, provided there is no stall.
- Throughput: 1 op/cycle.
- Advance: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - On adv, every stage shifts one position.
  - Stage 0 loads in_valid && in_ready.
  - Empty stages shift as bubbles.
  - When adv is 0, all stages, sum and flags hold.
- Output: out_valid, sum and flags are registered and stable while out_valid && !out_ready.
- Simultaneous events: out_ready with out_valid=1 in the same cycle as in_valid=1 accepts a new op and retires the old one; no bubble is inserted.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR cout.
  - zero = (sum == 0).
  - neg = sum[WIDTH-1].
  - All flags computed in the final stage and registered with sum.
- Wrap-around: sum is modulo 2^WIDTH; no saturation.
- STAGES=1: behaves as a registered full-width adder with latency 1.

Optional Feature:
- Macro: PIPE_ADDER_FLAGS_EN.
- Defined: ovf, zero and neg are computed and registered as above.
- Undefined: ovf, zero and neg are tied to 0 and their registers and logic are removed. cout remains functional in both builds.

Test Plan:
- WIDTH=8, STAGES=2; a=0x0C, b=0x03, sub=0, cin=0 -> sum=0x0F, cout=0, zero=0, out_valid exactly 2 cycles after acceptance.
- WIDTH=8, STAGES=2; a=0xFF, b=0xC0 -> sum=0xBF, cout=1, neg=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0.
- WIDTH=32, STAGES=4; sub=1: a=5, b=5 -> sum=0, zero=1, cout=1. Then a=3, b=5 -> sum=0xFFFFFFFE, cout=0, neg=1. Then sub=1, cin=1, a=10, b=3 -> sum=6.
- Back-to-back stream of 8 ops with out_ready=1 -> 8 consecutive out_valid cycles with results in order. Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, sum stable, no op lost or duplicated.
- Assert rst_n low for 1 cycle with 3 ops in flight -> out_valid=0 and sum=0 immediately. No stale results appear after release. The next op completes with the correct value.
- Build without PIPE_ADDER_FLAGS_EN; a=0x7F, b=0x01 (WIDTH=8) -> sum=0x80, ovf=0, neg=0, zero=0.

Source files
------------

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep carry-chained add/subtract unit with valid/ready on both sides.
// Status flags ovf/zero/neg exist only when PIPE_ADDER_FLAGS_EN is defined; cout is always live.
module pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);
   localparam int CW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic             adv;
   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   // Layer k holds the op waiting for stage k: chunks below k are finished sum
   // bits, chunks k and up are still raw A; beff_q keeps only the unused B chunks.
   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int RW = (STAGES - k) * CW;

      logic             valid_q, valid_d;
      logic             carry_q, carry_d;
      logic [WIDTH-1:0] word_q, word_d;
      logic [RW-1:0]    beff_q, beff_d;
      logic [CW:0]      add_w;
      logic [WIDTH-1:0] res_w;

      assign add_w = {1'b0, word_q[k*CW +: CW]} + {1'b0, beff_q[CW-1:0]}
                   + {{CW{1'b0}}, carry_q};

      always_comb begin
         res_w              = word_q;
         res_w[k*CW +: CW]  = add_w[CW-1:0];
      end

      if (k == 0) begin : g_first
         always_comb begin
            valid_d = in_valid && in_ready;
            carry_d = cin ^ sub;
            word_d  = a;
            beff_d  = sub ? ~b : b;
         end
      end else begin : g_next
         always_comb begin
            valid_d = g_stg[k-1].valid_q;
            carry_d = g_stg[k-1].add_w[CW];
            word_d  = g_stg[k-1].res_w;
            beff_d  = g_stg[k-1].beff_q[RW+CW-1:CW];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            word_q  <= '0;
            beff_q  <= '0;
         end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            word_q  <= word_d;
            beff_q  <= beff_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
      end else if (adv) begin
         out_valid_q <= g_stg[LAST].valid_q;
         sum_q       <= g_stg[LAST].res_w;
         cout_q      <= g_stg[LAST].add_w[CW];
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

`ifdef PIPE_ADDER_FLAGS_EN
   logic ovf_q, zero_q, neg_q;
   logic ovf_d, a_msb, b_msb, s_msb;

   // Same-sign operands producing an opposite-sign result is exactly
   // carry-into-MSB xor carry-out-of-MSB.
   assign a_msb = g_stg[LAST].word_q[WIDTH-1];
   assign b_msb = g_stg[LAST].beff_q[CW-1];
   assign s_msb = g_stg[LAST].res_w[WIDTH-1];
   assign ovf_d = (a_msb == b_msb) && (s_msb != a_msb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (adv) begin
         ovf_q  <= ovf_d;
         zero_q <= (g_stg[LAST].res_w == '0);
         neg_q  <= s_msb;
      end
   end

   assign ovf  = ovf_q;
   assign zero = zero_q;
   assign neg  = neg_q;
`else
   assign ovf  = 1'b0;
   assign zero = 1'b0;
   assign neg  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: instances 8b/2-stage, 8b/1-stage and 32b/4-stage checked against
// an arithmetic reference model; flag expectations follow PIPE_ADDER_FLAGS_EN.
module tb_pipe_adder;
   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
   } res_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        cin;
   } op_t;

   typedef struct {
      int   dut;
      op_t  op;
      res_t r;
   } dir_t;

`ifdef PIPE_ADDER_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logic       d8_iv, d8_ir, d8_ov, d8_or, d8_sub, d8_cin, d8_co, d8_ovf, d8_z, d8_n;
   logic [7:0] d8_a, d8_b, d8_s;
   logic       d1_iv, d1_ir, d1_ov, d1_or, d1_sub, d1_cin, d1_co, d1_ovf, d1_z, d1_n;
   logic [7:0] d1_a, d1_b, d1_s;
   logic        d32_iv, d32_ir, d32_ov, d32_or, d32_sub, d32_cin, d32_co, d32_ovf, d32_z, d32_n;
   logic [31:0] d32_a, d32_b, d32_s;

   pipe_adder #(.WIDTH(8), .STAGES(2)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(d8_iv), .in_ready(d8_ir), .a(d8_a), .b(d8_b),
      .sub(d8_sub), .cin(d8_cin), .out_valid(d8_ov), .out_ready(d8_or), .sum(d8_s),
      .cout(d8_co), .ovf(d8_ovf), .zero(d8_z), .neg(d8_n));

   pipe_adder #(.WIDTH(8), .STAGES(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(d1_iv), .in_ready(d1_ir), .a(d1_a), .b(d1_b),
      .sub(d1_sub), .cin(d1_cin), .out_valid(d1_ov), .out_ready(d1_or), .sum(d1_s),
      .cout(d1_co), .ovf(d1_ovf), .zero(d1_z), .neg(d1_n));

   pipe_adder #(.WIDTH(32), .STAGES(4)) u_d32 (
      .clk(clk), .rst_n(rst_n), .in_valid(d32_iv), .in_ready(d32_ir), .a(d32_a), .b(d32_b),
      .sub(d32_sub), .cin(d32_cin), .out_valid(d32_ov), .out_ready(d32_or), .sum(d32_s),
      .cout(d32_co), .ovf(d32_ovf), .zero(d32_z), .neg(d32_n));

   function automatic int width_of(int dut);
      return (dut == 2) ? 32 : 8;
   endfunction

   function automatic int stages_of(int dut);
      return (dut == 0) ? 2 : ((dut == 1) ? 1 : 4);
   endfunction

   // Reference: true unsigned and signed results, then reduced to WIDTH bits.
   function automatic res_t model(int w, op_t op);
      longint m, half, ua, ub, sa, sb, ci, u, s;
      res_t   r;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(op.a) & m;
      ub   = longint'(op.b) & m;
      sa   = (ua >= half) ? ua - 2 * half : ua;
      sb   = (ub >= half) ? ub - 2 * half : ub;
      ci   = op.cin ? 1 : 0;
      if (op.sub) begin
         u = ua - ub - ci;
         s = sa - sb - ci;
      end else begin
         u = ua + ub + ci;
         s = sa + sb + ci;
      end
      r.sum  = 32'(u & m);
      r.cout = op.sub ? (u >= 0) : (u > m);
      r.ovf  = FL && ((s >= half) || (s < -half));
      r.zero = FL && ((u & m) == 0);
      r.neg  = FL && ((u & half) != 0);
      return r;
   endfunction

   function automatic logic [31:0] rnd_word(int w);
      logic [31:0] m, v;
      m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      case ($urandom_range(0, 5))
         0:       v = '0;
         1:       v = m;
         2:       v = (m >> 1) + 32'd1;
         3:       v = m >> 1;
         default: v = $urandom;
      endcase
      return v & m;
   endfunction

   function automatic op_t rnd_op(int w);
      op_t op;
      op.a   = rnd_word(w);
      op.b   = rnd_word(w);
      op.sub = 1'($urandom_range(0, 1));
      op.cin = 1'($urandom_range(0, 1));
      return op;
   endfunction

   function automatic dir_t mk(int dut, logic [31:0] a, logic [31:0] b, logic sub, logic cin,
                               logic [31:0] s, logic [3:0] f);
      dir_t d;
      d.dut = dut;
      d.op  = {a, b, sub, cin};
      d.r   = {s, f[3], f[2:0] & {3{FL}}};
      return d;
   endfunction

   // Drive one cycle's inputs at the falling edge, then sample the outputs just after.
   task automatic cyc(input int dut, input op_t op, input logic iv, input logic ordy,
                      output logic ov, output logic ir, output res_t o);
      @(negedge clk);
      case (dut)
         0: begin
            d8_iv = iv; d8_a = op.a[7:0]; d8_b = op.b[7:0];
            d8_sub = op.sub; d8_cin = op.cin; d8_or = ordy;
         end
         1: begin
            d1_iv = iv; d1_a = op.a[7:0]; d1_b = op.b[7:0];
            d1_sub = op.sub; d1_cin = op.cin; d1_or = ordy;
         end
         default: begin
            d32_iv = iv; d32_a = op.a; d32_b = op.b;
            d32_sub = op.sub; d32_cin = op.cin; d32_or = ordy;
         end
      endcase
      #1;
      case (dut)
         0: begin
            ov = d8_ov; ir = d8_ir;
            o  = {24'h0, d8_s, d8_co, d8_ovf, d8_z, d8_n};
         end
         1: begin
            ov = d1_ov; ir = d1_ir;
            o  = {24'h0, d1_s, d1_co, d1_ovf, d1_z, d1_n};
         end
         default: begin
            ov = d32_ov; ir = d32_ir;
            o  = {d32_s, d32_co, d32_ovf, d32_z, d32_n};
         end
      endcase
   endtask

   task automatic idle();
      @(negedge clk);
      d8_iv = 1'b0; d1_iv = 1'b0; d32_iv = 1'b0;
      d8_or = 1'b1; d1_or = 1'b1; d32_or = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      d8_or = 1'b0; d1_or = 1'b0; d32_or = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({d8_ov, d1_ov, d32_ov} !== 3'b000) begin
         errors++;
         $display("FAIL reset_out_valid: got %b, want 000", {d8_ov, d1_ov, d32_ov});
      end
      checks++;
      if ({d8_s, d1_s, d32_s, d8_co, d1_co, d32_co, d8_ovf, d1_ovf, d32_ovf,
           d8_z, d1_z, d32_z, d8_n, d1_n, d32_n} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: sums %h %h %h couts %b%b%b, want all zero",
                  d8_s, d1_s, d32_s, d8_co, d1_co, d32_co);
      end
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({d8_ir, d1_ir, d32_ir} !== 3'b111) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, want 111", {d8_ir, d1_ir, d32_ir});
      end
      idle();
   endtask

   task automatic test_directed();
      dir_t t[8];
      logic ov, ir;
      res_t o, exp;
      int   lat;
      t[0] = mk(0, 32'h0C, 32'h03, 1'b0, 1'b0, 32'h0F, 4'b0000);
      t[1] = mk(0, 32'hFF, 32'hC0, 1'b0, 1'b0, 32'hBF, 4'b1001);
      t[2] = mk(0, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 4'b0101);
      t[3] = mk(2, 32'd5,  32'd5,  1'b1, 1'b0, 32'h0,  4'b1010);
      t[4] = mk(2, 32'd3,  32'd5,  1'b1, 1'b0, 32'hFFFF_FFFE, 4'b0001);
      t[5] = mk(2, 32'd10, 32'd3,  1'b1, 1'b1, 32'd6,  4'b1000);
      t[6] = mk(1, 32'hFF, 32'h01, 1'b0, 1'b1, 32'h01, 4'b1000);
      t[7] = mk(1, 32'h80, 32'h01, 1'b1, 1'b0, 32'h7F, 4'b1100);
      foreach (t[i]) begin
         exp = t[i].r;
         cyc(t[i].dut, t[i].op, 1'b1, 1'b1, ov, ir, o);
         checks++;
         if (ir !== 1'b1) begin
            errors++;
            $display("FAIL directed[%0d] accept: in_ready %b, want 1", i, ir);
         end
         lat = -1;
         for (int k = 1; k <= stages_of(t[i].dut) + 3; k++) begin
            cyc(t[i].dut, t[i].op, 1'b0, 1'b1, ov, ir, o);
            if (ov) begin
               lat = k - 1;
               break;
            end
         end
         checks++;
         if (lat != stages_of(t[i].dut)) begin
            errors++;
            $display("FAIL directed[%0d] latency: got %0d, want %0d", i, lat, stages_of(t[i].dut));
         end
         checks++;
         if (o !== exp) begin
            errors++;
            $display("FAIL directed[%0d] result: got %h, want %h", i, o, exp);
         end
         checks++;
         if (o !== model(width_of(t[i].dut), t[i].op)) begin
            errors++;
            $display("FAIL directed[%0d] model: got %h, want %h", i, o,
                     model(width_of(t[i].dut), t[i].op));
         end
      end
      idle();
   endtask

   task automatic test_back_to_back();
      op_t  ops[8];
      res_t q[$];
      res_t o, prev, e;
      logic ov, ir, stall;
      int   sent, got, first, last, idx;
      for (int run = 0; run < 2; run++) begin
         foreach (ops[i]) ops[i] = rnd_op(32);
         q.delete();
         sent = 0; got = 0; first = -1; last = -1;
         for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
            stall = (run == 1) && (c >= 6) && (c <= 8);
            idx   = (sent < 8) ? sent : 7;
            cyc(2, ops[idx], sent < 8, !stall, ov, ir, o);
            if (stall) begin
               checks++;
               if (ir !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_in_ready c=%0d: got %b, want 0", c, ir);
               end
               if (c > 6) begin
                  checks++;
                  if (ov !== 1'b1 || o !== prev) begin
                     errors++;
                     $display("FAIL stall_hold c=%0d: got v=%b %h, want v=1 %h", c, ov, o, prev);
                  end
               end
            end
            if (ov && !stall) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL b2b_extra run=%0d: got %h, want no result", run, o);
               end else begin
                  e = q.pop_front();
                  if (o !== e) begin
                     errors++;
                     $display("FAIL b2b_result run=%0d: got %h, want %h", run, o, e);
                  end
               end
               got++;
               if (first < 0) first = c;
               last = c;
            end
            if (sent < 8 && ir) begin
               q.push_back(model(32, ops[sent]));
               sent++;
            end
            prev = o;
         end
         checks++;
         if (got != 8 || q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count run=%0d: got %0d results %0d pending, want 8 and 0",
                     run, got, q.size());
         end
         if (run == 0) begin
            checks++;
            if (last - first + 1 != 8) begin
               errors++;
               $display("FAIL b2b_consecutive: got span %0d, want 8", last - first + 1);
            end
         end
      end
      idle();
   endtask

   task automatic test_reset_inflight();
      op_t  ops[3];
      op_t  nop;
      res_t o, e;
      logic ov, ir;
      int   lat;
      foreach (ops[i]) ops[i] = rnd_op(32);
      for (int c = 0; c < 6; c++)
         cyc(2, ops[(c < 3) ? c : 0], c < 3, 1'b0, ov, ir, o);
      checks++;
      if (ov !== 1'b1) begin
         errors++;
         $display("FAIL inflight_pre_valid: got %b, want 1", ov);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (d32_ov !== 1'b0 || d32_s !== 32'h0 || d32_co !== 1'b0) begin
         errors++;
         $display("FAIL inflight_reset: got v=%b sum=%h cout=%b, want 0 0 0", d32_ov, d32_s, d32_co);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         cyc(2, ops[0], 1'b0, 1'b1, ov, ir, o);
         checks++;
         if (ov !== 1'b0) begin
            errors++;
            $display("FAIL inflight_stale c=%0d: got v=1 sum=%h, want v=0", c, o.sum);
         end
      end
      nop = rnd_op(32);
      e   = model(32, nop);
      cyc(2, nop, 1'b1, 1'b1, ov, ir, o);
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
         cyc(2, nop, 1'b0, 1'b1, ov, ir, o);
         if (ov) begin
            lat = k - 1;
            break;
         end
      end
      checks++;
      if (lat != 4 || o !== e) begin
         errors++;
         $display("FAIL inflight_next: got lat=%0d %h, want lat=4 %h", lat, o, e);
      end
      idle();
   endtask

   task automatic test_random();
      res_t q[$];
      res_t o, prev, e;
      op_t  cur;
      logic ov, ir, iv, ordy, stall_prev;
      int   sent, n_cyc, w;
      for (int dut = 0; dut < 3; dut++) begin
         w = width_of(dut);
         q.delete();
         sent = 0; n_cyc = 0; stall_prev = 1'b0;
         cur = rnd_op(w);
         while ((sent < 150 || q.size() > 0) && n_cyc < 3000) begin
            iv   = (sent < 150) && ($urandom_range(0, 99) < 75);
            ordy = ($urandom_range(0, 99) < 70);
            cyc(dut, cur, iv, ordy, ov, ir, o);
            checks++;
            if (ir !== (!ov || ordy)) begin
               errors++;
               $display("FAIL rand_in_ready dut=%0d: got %b, want %b", dut, ir, !ov || ordy);
            end
            if (stall_prev) begin
               checks++;
               if (ov !== 1'b1 || o !== prev) begin
                  errors++;
                  $display("FAIL rand_hold dut=%0d: got v=%b %h, want v=1 %h", dut, ov, o, prev);
               end
            end
            if (ov && ordy) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL rand_extra dut=%0d: got %h, want no result", dut, o);
               end else begin
                  e = q.pop_front();
                  if (o !== e) begin
                     errors++;
                     $display("FAIL rand_result dut=%0d: got %h, want %h", dut, o, e);
                  end
               end
            end
            if (iv && ir) begin
               q.push_back(model(w, cur));
               sent++;
               cur = rnd_op(w);
            end
            stall_prev = ov && !ordy;
            prev       = o;
            n_cyc++;
         end
         checks++;
         if (sent != 150 || q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain dut=%0d: got %0d sent %0d pending, want 150 and 0",
                     dut, sent, q.size());
         end
         idle();
      end
   endtask

   initial begin
      d8_iv = 1'b0; d8_a = '0; d8_b = '0; d8_sub = 1'b0; d8_cin = 1'b0; d8_or = 1'b1;
      d1_iv = 1'b0; d1_a = '0; d1_b = '0; d1_sub = 1'b0; d1_cin = 1'b0; d1_or = 1'b1;
      d32_iv = 1'b0; d32_a = '0; d32_b = '0; d32_sub = 1'b0; d32_cin = 1'b0; d32_or = 1'b1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_inflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
